keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_pkg.sv | 62 ++++++
 rtl/scan_tick_gen.sv | 32 +++
 rtl/keypad_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad scanner: FSM encodings, special key
// codes, matrix geometry and the key-decode / digit-buffer helper functions.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  typedef struct packed {
    logic [31:0] digits;
    logic [3:0]  count;
  } digit_state_t;

  // Bottom row is * 0 #; the upper three rows are 1..9 in reading order.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'h0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  function automatic logic [1:0] col_index(input logic [NUM_COLS-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    if (cols[1]) idx = 2'd1;
    if (cols[2]) idx = 2'd2;
    return idx;
  endfunction

  // Digits shift in at the low nibble, '*' drops the newest, '#' clears.
  function automatic digit_state_t apply_key(input digit_state_t cur, input logic [3:0] code);
    digit_state_t nxt;
    nxt = cur;
    if (code == KEY_HASH) begin
      nxt = '0;
    end else if (code == KEY_STAR) begin
      if (cur.count != 4'd0) begin
        nxt.digits = {4'h0, cur.digits[31:4]};
        nxt.count  = cur.count - 4'd1;
      end
    end else begin
      nxt.digits = {cur.digits[27:0], code};
      nxt.count  = (cur.count >= 4'd8) ? 4'd8 : cur.count + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Row-advance tick generator: one-cycle enable every clk_freq/scan_rate
// cycles (at least every cycle).
module scan_tick_gen #(
  parameter logic [27:0] clk_freq  = 28'd1000_0000,
  parameter logic [27:0] scan_rate = 28'd500_0000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [27:0] RAW    = (scan_rate == 28'd0) ? 28'd1 : clk_freq / scan_rate;
  localparam logic [27:0] PERIOD = (RAW == 28'd0) ? 28'd1 : RAW;
  localparam logic [27:0] LAST   = PERIOD - 28'd1;

  logic [27:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: clocked state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 28'd1;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x3 matrix keypad scanner with tick-based press/release debounce and an
// eight-digit entry buffer supporting backspace ('*') and clear ('#').
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter logic [27:0] clk_freq  = 28'd1000_0000,
  parameter logic [27:0] scan_rate = 28'd500_0000,
  parameter int          deb_ticks = 2
) (
  input  logic        sys_clk_in,
  input  logic        reset,
  input  logic        E,
  input  logic        F,
  input  logic        G,
  output logic [3:0]  pin_control,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [31:0] digit_buf,
  output logic [3:0]  digit_cnt
);

  localparam logic [3:0] DEB = 4'(deb_ticks);

  logic                        tick;
  logic [1:0]                  state;
  logic [$clog2(NUM_ROWS)-1:0] row_idx;
  logic [NUM_COLS-1:0]         col_lat;
  logic [NUM_COLS-1:0]         cols;
  logic [3:0]                  deb_cnt;
  logic [3:0]                  rel_cnt;
  logic                        cols_onehot;
  logic                        confirm;
  logic [3:0]                  confirm_code;
  digit_state_t                digits_q;

  scan_tick_gen #(
    .clk_freq  (clk_freq),
    .scan_rate (scan_rate)
  ) u_tick (
    .clk   (sys_clk_in),
    .rst_n (reset),
    .tick  (tick)
  );

  // NOTE: every signal written here gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    cols         = {G, F, E};
    cols_onehot  = (cols == 3'b001) || (cols == 3'b010) || (cols == 3'b100);
    confirm      = 1'b0;
    confirm_code = key_lookup(row_idx, col_index(col_lat));
    if (tick) begin
      if (state == ST_SCAN && cols_onehot && DEB <= 4'd1) begin
        confirm      = 1'b1;
        confirm_code = key_lookup(row_idx, col_index(cols));
      end else if (state == ST_DEBOUNCE && cols == col_lat && deb_cnt + 4'd1 >= DEB) begin
        confirm = 1'b1;
      end
    end
  end

  // Row stays frozen outside SCAN so the latched column keeps meaning.
  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      state   <= ST_SCAN;
      row_idx <= '0;
      col_lat <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
    end else if (tick) begin
      case (state)
        ST_SCAN: begin
          if (cols_onehot) begin
            col_lat <= cols;
            deb_cnt <= 4'd1;
            rel_cnt <= '0;
            state   <= (DEB <= 4'd1) ? ST_HELD : ST_DEBOUNCE;
          end else begin
            row_idx <= row_idx + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (cols == col_lat) begin
            deb_cnt <= deb_cnt + 4'd1;
            if (confirm) begin
              state   <= ST_HELD;
              rel_cnt <= '0;
            end
          end else begin
            deb_cnt <= '0;
            state   <= ST_SCAN;
            row_idx <= row_idx + 1'b1;
          end
        end
        ST_HELD: begin
          if (cols == 3'b000) begin
            if (rel_cnt + 4'd1 >= DEB) begin
              state   <= ST_SCAN;
              rel_cnt <= '0;
              deb_cnt <= '0;
            end else begin
              rel_cnt <= rel_cnt + 4'd1;
            end
          end else begin
            rel_cnt <= '0;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      digits_q  <= '0;
    end else begin
      key_valid <= confirm;
      if (confirm) begin
        key_code <= confirm_code;
        digits_q <= apply_key(digits_q, confirm_code);
      end
    end
  end

  assign pin_control = 4'b0001 << row_idx;
  assign key_held    = (state == ST_HELD);
  assign digit_buf   = digits_q.digits;
  assign digit_cnt   = digits_q.count;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl at default parameters (tick every 2 cycles).
module tb_keypad_scan_ctrl;

  logic        sys_clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        E, F, G;
  logic [3:0]  pin_control, key_code, digit_cnt;
  logic        key_valid, key_held;
  logic [31:0] digit_buf;

  int total = 0;
  int bad   = 0;
  int kv_count = 0;

  logic [2:0] pressed [4];
  logic       direct;
  logic [2:0] direct_cols;
  logic [2:0] cols_drv;

  keypad_scan_ctrl dut (
    .sys_clk_in  (sys_clk_in),
    .reset       (reset),
    .E           (E),
    .F           (F),
    .G           (G),
    .pin_control (pin_control),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .digit_buf   (digit_buf),
    .digit_cnt   (digit_cnt)
  );

  always #5 sys_clk_in = ~sys_clk_in;

  // Matrix model: a pressed key shorts its row strobe onto its column.
  always_comb begin
    cols_drv = 3'b000;
    if (direct) begin
      cols_drv = direct_cols;
    end else begin
      for (int r = 0; r < 4; r++)
        if (pin_control[r] === 1'b1) cols_drv = cols_drv | pressed[r];
    end
  end
  assign {G, F, E} = cols_drv;

  always @(posedge sys_clk_in) begin
    #1;
    if (key_valid === 1'b1) kv_count++;
  end

  task automatic do_reset();
    @(negedge sys_clk_in);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk_in);
    reset = 1'b1;
  endtask

  task automatic press_key(input int row, input int col, input int hold);
    int start;
    int n;
    start = kv_count;
    pressed[row] = 3'(1 << col);
    n = 0;
    while (kv_count == start && n < 60) begin
      @(negedge sys_clk_in);
      n++;
    end
    total++;
    if (kv_count != start + 1) begin
      bad++;
      $display("FAIL press_r%0d_c%0d: key_valid pulses=%0d required 1", row, col, kv_count - start);
    end
    repeat (hold) @(negedge sys_clk_in);
    pressed[row] = 3'b000;
    n = 0;
    while (key_held !== 1'b0 && n < 20) begin
      @(negedge sys_clk_in);
      n++;
    end
    repeat (2) @(negedge sys_clk_in);
    total++;
    if (key_held !== 1'b0 || kv_count != start + 1) begin
      bad++;
      $display("FAIL release_r%0d_c%0d: key_held=%b pulses=%0d required 0/1", row, col, key_held, kv_count - start);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    total++; if (pin_control !== 4'b0001) begin bad++; $display("FAIL reset_pin: got %b want 0001", pin_control); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", key_held); end
    total++; if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code: got %h want 0", key_code); end
    total++; if (digit_buf !== 32'h0) begin bad++; $display("FAIL reset_buf: got %h want 0", digit_buf); end
    total++; if (digit_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", digit_cnt); end
    repeat (2) @(negedge sys_clk_in);
    reset = 1'b1;
  endtask

  task automatic test_single_key();
    int kv0;
    kv0 = kv_count;
    pressed[0] = 3'b001;
    repeat (12) @(negedge sys_clk_in);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL single_held: got %b want 1", key_held); end
    total++; if (kv_count != kv0 + 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", kv_count - kv0); end
    total++; if (key_code !== 4'h1) begin bad++; $display("FAIL single_code: got %h want 1", key_code); end
    total++; if (digit_buf !== 32'h00000001) begin bad++; $display("FAIL single_buf: got %h want 00000001", digit_buf); end
    total++; if (digit_cnt !== 4'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", digit_cnt); end
    pressed[0] = 3'b000;
    @(negedge sys_clk_in);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL single_release_early: got %b want 1", key_held); end
    repeat (3) @(negedge sys_clk_in);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL single_release: got %b want 0", key_held); end
    repeat (4) @(negedge sys_clk_in);
    total++; if (pin_control !== 4'b0100) begin bad++; $display("FAIL single_rescan: got %b want 0100", pin_control); end
    total++; if (kv_count != kv0 + 1) begin bad++; $display("FAIL single_repeat: got %0d want 1", kv_count - kv0); end
  endtask

  task automatic test_glitch();
    int kv0;
    do_reset();
    kv0 = kv_count;
    direct = 1'b1;
    direct_cols = 3'b001;
    repeat (2) @(negedge sys_clk_in);
    direct_cols = 3'b000;
    repeat (2) @(negedge sys_clk_in);
    total++; if (pin_control !== 4'b0010) begin bad++; $display("FAIL glitch_pin: got %b want 0010", pin_control); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL glitch_held: got %b want 0", key_held); end
    total++; if (kv_count != kv0) begin bad++; $display("FAIL glitch_pulses: got %0d want 0", kv_count - kv0); end
    direct = 1'b0;
  endtask

  task automatic test_multi_col();
    int kv0;
    int changes;
    int held_seen;
    logic [3:0] prev;
    do_reset();
    kv0 = kv_count;
    direct = 1'b1;
    direct_cols = 3'b011;
    changes = 0;
    held_seen = 0;
    prev = pin_control;
    repeat (20) begin
      @(negedge sys_clk_in);
      if (pin_control !== prev) changes++;
      if (key_held === 1'b1) held_seen++;
      prev = pin_control;
    end
    total++; if (changes != 10) begin bad++; $display("FAIL multi_rotate: got %0d want 10", changes); end
    total++; if (held_seen != 0) begin bad++; $display("FAIL multi_held: got %0d want 0", held_seen); end
    total++; if (kv_count != kv0) begin bad++; $display("FAIL multi_pulses: got %0d want 0", kv_count - kv0); end
    direct = 1'b0;
    direct_cols = 3'b000;
  endtask

  task automatic test_digits();
    do_reset();
    for (int d = 1; d <= 9; d++) begin
      press_key((d - 1) / 3, (d - 1) % 3, 4);
      if (d == 8) begin
        total++; if (digit_buf !== 32'h12345678 || digit_cnt !== 4'd8) begin
          bad++; $display("FAIL digits_8: got %h/%0d want 12345678/8", digit_buf, digit_cnt);
        end
      end
    end
    total++; if (digit_buf !== 32'h23456789 || digit_cnt !== 4'd8) begin
      bad++; $display("FAIL digits_9: got %h/%0d want 23456789/8", digit_buf, digit_cnt);
    end
    press_key(3, 0, 4);
    total++; if (digit_buf !== 32'h02345678 || digit_cnt !== 4'd7 || key_code !== 4'hA) begin
      bad++; $display("FAIL star: got %h/%0d/%h want 02345678/7/a", digit_buf, digit_cnt, key_code);
    end
    press_key(3, 2, 4);
    total++; if (digit_buf !== 32'h0 || digit_cnt !== 4'd0 || key_code !== 4'hB) begin
      bad++; $display("FAIL hash: got %h/%0d/%h want 0/0/b", digit_buf, digit_cnt, key_code);
    end
    press_key(3, 1, 4);
    total++; if (digit_buf !== 32'h0 || digit_cnt !== 4'd1 || key_code !== 4'h0) begin
      bad++; $display("FAIL zero: got %h/%0d/%h want 0/1/0", digit_buf, digit_cnt, key_code);
    end
    press_key(3, 0, 4);
    press_key(3, 0, 4);
    total++; if (digit_buf !== 32'h0 || digit_cnt !== 4'd0) begin
      bad++; $display("FAIL star_empty: got %h/%0d want 0/0", digit_buf, digit_cnt);
    end
  endtask

  task automatic test_hold();
    int kv0;
    int n;
    int low_seen;
    do_reset();
    kv0 = kv_count;
    pressed[1] = 3'b010;
    n = 0;
    while (kv_count == kv0 && n < 40) begin
      @(negedge sys_clk_in);
      n++;
    end
    low_seen = 0;
    repeat (40) begin
      @(negedge sys_clk_in);
      if (key_held !== 1'b1) low_seen++;
    end
    total++; if (low_seen != 0) begin bad++; $display("FAIL hold_held: low cycles=%0d want 0", low_seen); end
    total++; if (kv_count != kv0 + 1) begin bad++; $display("FAIL hold_pulses: got %0d want 1", kv_count - kv0); end
    total++; if (key_code !== 4'h5 || digit_buf !== 32'h5) begin
      bad++; $display("FAIL hold_code: got %h/%h want 5/00000005", key_code, digit_buf);
    end
    pressed[1] = 3'b000;
    repeat (6) @(negedge sys_clk_in);
  endtask

  task automatic test_reset_debounce();
    int kv0;
    int n;
    do_reset();
    kv0 = kv_count;
    pressed[1] = 3'b001;
    n = 0;
    while (pin_control !== 4'b0010 && n < 20) begin
      @(negedge sys_clk_in);
      n++;
    end
    repeat (2) @(negedge sys_clk_in);
    total++; if (pin_control !== 4'b0010 || kv_count != kv0) begin
      bad++; $display("FAIL rstdeb_setup: pin=%b pulses=%0d want 0010/0", pin_control, kv_count - kv0);
    end
    #2 reset = 1'b0;
    #1;
    total++; if (pin_control !== 4'b0001) begin bad++; $display("FAIL rstdeb_pin: got %b want 0001", pin_control); end
    total++; if (key_held !== 1'b0 || key_valid !== 1'b0) begin
      bad++; $display("FAIL rstdeb_flags: held=%b valid=%b want 0/0", key_held, key_valid);
    end
    pressed[1] = 3'b000;
    repeat (2) @(negedge sys_clk_in);
    reset = 1'b1;
    repeat (10) @(negedge sys_clk_in);
    total++; if (kv_count != kv0) begin bad++; $display("FAIL rstdeb_pulses: got %0d want 0", kv_count - kv0); end
    total++; if (key_code !== 4'h0 || digit_buf !== 32'h0) begin
      bad++; $display("FAIL rstdeb_clear: got %h/%h want 0/0", key_code, digit_buf);
    end
  endtask

  initial begin
    for (int r = 0; r < 4; r++) pressed[r] = 3'b000;
    direct = 1'b0;
    direct_cols = 3'b000;
    test_reset();
    test_single_key();
    test_glitch();
    test_multi_col();
    test_digits();
    test_hold();
    test_reset_debounce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
